// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StArmed, StMatch} state_e;

  localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
  localparam int unsigned DEF_LEN = 4;

  // Width needed to hold a length in the range 0..max_len.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// input qualifier, saturating match counter and config-error reporting.
module seq_det_prog #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
  parameter int unsigned          DEF_LEN     = seq_det_pkg::DEF_LEN,
  parameter int unsigned          CNT_W       = 8
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in,
  input  logic                                             in_valid,
  input  logic                                             mode_ovl,
  input  logic                                             cfg_we,
  input  logic [MAX_LEN-1:0]                               cfg_pattern,
  input  logic [seq_det_pkg::len_width(MAX_LEN)-1:0]       cfg_len,
  input  logic                                             cnt_clr,
  output logic                                             out,
  output logic [CNT_W-1:0]                                 match_cnt,
  output logic                                             cfg_err
);

  import seq_det_pkg::*;

  localparam int unsigned LW = len_width(MAX_LEN);
  localparam logic [LW-1:0] MaxLenW = LW'(MAX_LEN);

  // The oldest history bit is shifted out on the very edge it would be used,
  // so only MAX_LEN-1 bits need to be stored.
  logic [MAX_LEN-2:0] history_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LW-1:0]      fill_q;
  logic [LW-1:0]      len_q;
  state_e             state_q;
  logic               out_q;
  logic               cfg_err_q;

  logic [MAX_LEN-1:0] h_next;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      f_next;
  logic               cfg_ok;
  logic               hit;

  function automatic state_e fill_state(input logic [LW-1:0] f, input logic [LW-1:0] l);
    if (f == '0)     return StIdle;
    else if (f == l) return StArmed;
    else             return StFill;
  endfunction

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len_q);
    end
    h_next = {history_q, in};
    f_next = (fill_q >= len_q) ? len_q : fill_q + LW'(1);
    cfg_ok = cfg_we && (cfg_len != '0) && (cfg_len <= MaxLenW);
    hit    = in_valid && !cfg_ok && (f_next == len_q) &&
             (((h_next ^ pattern_q) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history_q <= '0;
      pattern_q <= DEF_PATTERN;
      fill_q    <= '0;
      len_q     <= LW'(DEF_LEN);
      state_q   <= StIdle;
      out_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        // The in bit on a config edge is dropped; matching restarts from empty.
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        history_q <= '0;
        fill_q    <= '0;
        state_q   <= StIdle;
        out_q     <= 1'b0;
      end else if (in_valid) begin
        if (hit) begin
          state_q <= StMatch;
          out_q   <= 1'b1;
          if (mode_ovl) begin
            history_q <= h_next[MAX_LEN-2:0];
            fill_q    <= len_q;
          end else begin
            history_q <= '0;
            fill_q    <= '0;
          end
        end else begin
          history_q <= h_next[MAX_LEN-2:0];
          fill_q    <= f_next;
          state_q   <= fill_state(f_next, len_q);
          out_q     <= 1'b0;
        end
      end else begin
        out_q <= 1'b0;
        case (state_q)
          StMatch:                 state_q <= fill_state(fill_q, len_q);
          StIdle, StFill, StArmed: state_q <= state_q;
          default:                 state_q <= StIdle;
        endcase
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(hit),
    .q  (match_cnt)
  );

  assign out     = out_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: bit-queue reference model plus directed scenarios.
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;

  logic       clk;
  logic       rst;
  logic       in;
  logic       in_valid;
  logic       mode_ovl;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cnt_clr;

  logic       out_a, err_a, out_b, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  seq_det_prog u_dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .mode_ovl(mode_ovl),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
    .out(out_a), .match_cnt(cnt_a), .cfg_err(err_a)
  );

  seq_det_prog #(
    .CNT_W(2)
  ) u_dut_w2 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .mode_ovl(mode_ovl),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
    .out(out_b), .match_cnt(cnt_b), .cfg_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the bits received since the last clear, newest at the back.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  int         m_cnt8, m_cnt2;
  logic       m_out, m_err;

  // Per-scenario observation of where pulses land.
  int          bit_idx;
  logic [31:0] pulse_mask;
  int          pulse_n;
  int          err_n;

  function automatic void model_reset();
    mq.delete();
    m_pat  = 8'b0000_1011;
    m_len  = 4;
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_out  = 1'b0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_step();
    logic ok;
    logic hit;
    hit   = 1'b0;
    ok    = (cfg_len >= 1) && (int'(cfg_len) <= MAX_LEN);
    m_err = cfg_we && !ok;
    m_out = 1'b0;
    if (cfg_we && ok) begin
      m_pat = cfg_pattern;
      m_len = int'(cfg_len);
      mq.delete();
    end else if (in_valid) begin
      mq.push_back(in);
      if (mq.size() > 32) void'(mq.pop_front());
      hit = (mq.size() >= m_len);
      for (int k = 0; k < m_len && hit; k++) begin
        if (mq[mq.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit) begin
        m_out = 1'b1;
        if (!mode_ovl) mq.delete();
      end
    end
    if (cnt_clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (hit) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endfunction

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) begin
      model_step();
      #1;
      check("out", 32'(out_a), 32'(m_out));
      check("out_w2", 32'(out_b), 32'(m_out));
      check("match_cnt", 32'(cnt_a), 32'(m_cnt8));
      check("match_cnt_w2", 32'(cnt_b), 32'(m_cnt2));
      check("cfg_err", 32'(err_a), 32'(m_err));
      if (out_a) begin
        pulse_mask[bit_idx] = 1'b1;
        pulse_n++;
      end
      if (err_a) err_n++;
    end
  end

  task automatic drive(input logic b, input logic v, input logic we, input logic [7:0] pat,
                       input logic [3:0] len, input logic clr);
    @(negedge clk);
    in          = b;
    in_valid    = v;
    cfg_we      = we;
    cfg_pattern = pat;
    cfg_len     = len;
    cnt_clr     = clr;
    if (v && !(we && len >= 1 && len <= 8)) bit_idx++;
  endtask

  task automatic send(input logic b);
    drive(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) drive(b, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic send_seq(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) send(v[i]);
  endtask

  task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len);
    drive(1'b0, 1'b0, 1'b1, pat, len, 1'b0);
  endtask

  // Clear the counter, then zero the per-scenario observations.
  task automatic start();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1);
    idle(1, 1'b0);
    bit_idx    = 0;
    pulse_mask = '0;
    pulse_n    = 0;
    err_n      = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in = 1'b0; in_valid = 1'b0; mode_ovl = 1'b1; cfg_we = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cnt_clr = 1'b0;
    bit_idx = 0; pulse_mask = '0; pulse_n = 0; err_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(out_a), 32'd0);
    check("reset_cnt", 32'(cnt_a), 32'd0);
    check("reset_cfg_err", 32'(err_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Default 1011, overlapping.
    cfg_write(8'b1011, 4'd4);
    start();
    mode_ovl = 1'b1;
    send_seq(32'b1011011, 7);
    idle(2, 1'b0);
    check("t1_pulse_pos", pulse_mask, 32'h90);
    check("t1_pulse_n", 32'(pulse_n), 32'd2);
    check("t1_cnt", 32'(cnt_a), 32'd2);

    // Same stream, non-overlapping.
    cfg_write(8'b1011, 4'd4);
    start();
    mode_ovl = 1'b0;
    send_seq(32'b1011011, 7);
    idle(2, 1'b0);
    check("t2_pulse_pos", pulse_mask, 32'h10);
    check("t2_cnt", 32'(cnt_a), 32'd1);

    // Pattern 111, len 3, both modes.
    cfg_write(8'b111, 4'd3);
    start();
    mode_ovl = 1'b1;
    send_seq(32'b11111, 5);
    idle(2, 1'b0);
    check("t3_ovl_pulse_pos", pulse_mask, 32'h38);
    check("t3_ovl_cnt", 32'(cnt_a), 32'd3);
    cfg_write(8'b111, 4'd3);
    start();
    mode_ovl = 1'b0;
    send_seq(32'b11111, 5);
    idle(2, 1'b0);
    check("t3_novl_pulse_pos", pulse_mask, 32'h08);
    check("t3_novl_cnt", 32'(cnt_a), 32'd1);

    // Stalls with in=1 between bits.
    cfg_write(8'b1011, 4'd4);
    start();
    mode_ovl = 1'b1;
    begin
      logic [3:0] s;
      s = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        send(s[i]);
        idle(2, 1'b1);
      end
    end
    check("t4_pulse_pos", pulse_mask, 32'h10);
    check("t4_pulse_n", 32'(pulse_n), 32'd1);

    // Rejected and coincident config writes.
    cfg_write(8'b1011, 4'd4);
    start();
    cfg_write(8'hFF, 4'd0);
    idle(2, 1'b0);
    check("t5_err_n", 32'(err_n), 32'd1);
    send_seq(32'b1011, 4);
    send_seq(32'b101, 3);
    drive(1'b1, 1'b1, 1'b1, 8'b1011, 4'd4, 1'b0);
    send(1'b1);
    send_seq(32'b01, 2);
    drive(1'b1, 1'b1, 1'b1, 8'h00, 4'd9, 1'b0);
    idle(2, 1'b0);
    check("t5_pulse_pos", pulse_mask, 32'h810);
    check("t5_pulse_n", 32'(pulse_n), 32'd2);
    check("t5_err_n2", 32'(err_n), 32'd2);

    // Saturation, clear vs hit, asynchronous reset mid-pattern.
    cfg_write(8'b1011, 4'd4);
    start();
    mode_ovl = 1'b1;
    send_seq(32'b1011_0110_1101_1011, 16);
    idle(2, 1'b0);
    check("t6_cnt8", 32'(cnt_a), 32'd5);
    check("t6_cnt_sat", 32'(cnt_b), 32'd3);
    send_seq(32'b01, 2);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
    @(posedge clk);
    #2;
    check("t6_clr_hit_out", 32'(out_a), 32'd1);
    check("t6_clr_hit_cnt", 32'(cnt_a), 32'd0);
    check("t6_clr_hit_cnt_w2", 32'(cnt_b), 32'd0);
    send_seq(32'b011, 3);
    send_seq(32'b01, 2);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_out", 32'(out_a), 32'd0);
    check("t6_rst_cnt", 32'(cnt_a), 32'd0);
    check("t6_rst_cfg_err", 32'(err_a), 32'd0);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    bit_idx = 0; pulse_mask = '0; pulse_n = 0;
    send(1'b1);
    idle(1, 1'b0);
    check("t6_after_rst_no_pulse", 32'(pulse_n), 32'd0);
    send_seq(32'b011, 3);
    idle(2, 1'b0);
    check("t6_after_rst_pulse_pos", pulse_mask, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
